alu_decode_stage: RTL
=====================

# alu_decode_stage

Registered RV32I integer-ALU decode stage that sits between instruction fetch and the combinational ALU. It accepts one instruction per cycle over a valid/ready handshake and decodes OP, OP-IMM, LUI and AUIPC into the ALU control fields: `operation[2:0]`, `logic_arithmetic` and `add_sub`. It also produces operand-select flags, the immediate and register indices. Output is through a 2-entry skid buffer, so full throughput holds under backpressure and `in_ready` is driven from a register.

## Interface
- `XLEN`, 32, datapath width; only 32 is supported.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `flush`  in  1  drop all buffered entries.
- `in_valid`  in  1  upstream instruction valid.
- `in_ready`  out  1  stage can accept.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  32  instruction address.
- `out_valid`  out  1  decoded entry valid.
- `out_ready`  in  1  downstream accepts.
- `out_pc`  out  32  passed-through pc.
- `out_imm`  out  32  decoded immediate.
- `out_rs1`, `out_rs2`, `out_rd`  out  5 each  register indices.
- `out_src_a_pc`  out  1  ALU operand_a = pc (AUIPC).
- `out_src_a_zero`  out  1  ALU operand_a = 0 (LUI).
- `out_src_b_imm`  out  1  ALU operand_b = `out_imm`.
- `out_mask_b5`  out  1  operand mux zeroes operand_b[31:5] (register shifts).
- `out_operation`  out  3  ALU operation code.
- `out_logic_arithmetic`  out  1  SRA/SRAI select.
- `out_add_sub`  out  1  1 = subtract.
- `out_wb_en`  out  1  result written to rd.
- `out_illegal`  out  1  undecodable instruction.

## Operation
- **ALU op map (funct3 → operation):**
  - 0→0 add/sub; 1→1 sll; 2→2 slt; 3→3 sltu; 4→4 xor; 5→5 srl/sra.
  - 6 (OR)→7 and 7 (AND)→6. The ALU encodes AND=6 and OR=7, so the decoder must swap these two.
- **add_sub:** `funct7[5]`, only for OP with funct3=0. Always 0 for OP-IMM, LUI and AUIPC.
- **logic_arithmetic:** `funct7[5]` / `imm[10]` when funct3=5; 0 otherwise.
- **OP:**
  - `src_b_imm`=0; `mask_b5`=1 for funct3 1/5.
  - Legal funct7 is 0x00 for every funct3; 0x20 is legal only with funct3 0 or 5.
- **OP-IMM:**
  - `src_b_imm`=1; imm = sign-extended I-immediate.
  - For funct3 1/5, `out_imm` = {27'b0, shamt}. The ALU shifts by the whole operand_b and returns all ones for arithmetic shifts above 31.
  - Legal `imm[11:5]`: 0x00 for SLLI/SRLI, 0x20 for SRAI.
- **LUI:** `src_a_zero`=1, `src_b_imm`=1, operation 0, imm = {instr[31:12], 12'b0}.
- **AUIPC:** same as LUI but `src_a_pc`=1 instead of `src_a_zero`.
- **Illegal** (any other opcode or illegal funct7):
  - `illegal`=1, `wb_en`=0, all ALU and select fields 0.
  - The entry still flows downstream in order.
- **wb_en:** 1 only for a legal instruction with rd≠0. rs2=0 for OP-IMM, LUI and AUIPC.
- **Skid buffer:** a main output register plus one skid register, each holding the full decoded word.
  - Accept: `in_valid & in_ready`.
  - Downstream transfer: `out_valid & out_ready`.
  - Entry order is strictly FIFO.

## Timing
- **Reset** (while `rst_n`=0 at an edge): `out_valid`=0, skid empty, `in_ready`=1, all `out_*` data = 0.
- **Latency:** an instruction accepted at edge N shows `out_valid`=1 after edge N.
- **Throughput:** 1 per cycle while `out_ready`=1.
- **`in_ready`** = registered ¬skid_valid, so it never depends combinationally on `out_ready`.
- **Stall:** with `out_valid & ~out_ready`, the next accepted entry goes into skid and `in_ready` drops after that edge. When `out_ready` returns, skid moves to main and `in_ready` rises on the following edge.
- **Simultaneous accept and transfer:**
  - Skid empty: main is replaced by the new entry.
  - Skid full: main ← skid; `in_ready` is already 0, so no accept occurs.
- **flush:** `out_valid`=0, skid empty, `in_ready`=1 after the edge. Any entry offered in the same cycle is dropped.
- **Priority:** `rst_n` > `flush` > handshake.
- **Data stability:** `out_*` data is stable while `out_valid & ~out_ready`.

## Structure
- **Package `alu_pkg`:**
  - Opcode constants (OP 7'h33, OP_IMM 7'h13, LUI 7'h37, AUIPC 7'h17).
  - ALU codes ALU_ADD=0, SLL=1, SLT=2, SLTU=3, XOR=4, SR=5, AND=6, OR=7.
  - RV funct3 constants.
  - Packed struct `alu_dec_t` holding every `out_*` field except valid.
- **Sub-module `alu_decode_comb`:** purely combinational `in_instr`/`in_pc` → `alu_dec_t`, instantiated once at the input.
- **Top level:** two `alu_dec_t` registers plus the valid/ready control.

## Test plan
- **ADD x3,x1,x2** (0x002081B3), `out_ready`=1 → next cycle `out_valid`=1, operation 0, add_sub 0, rs1=1, rs2=2, rd=3, wb_en 1, src_b_imm 0.
- **SUB x5,x6,x7** (0x407302B3) → add_sub 1. **OR x3,x1,x2** (0x0020E1B3) → operation 7. **AND** (funct3 7) → operation 6.
- **SRAI x1,x2,4** (0x40415093) → operation 5, logic_arithmetic 1, src_b_imm 1, out_imm 0x00000004, mask_b5 0.
- **LUI x10,0x12345** (0x12345537) → src_a_zero 1, out_imm 0x12345000, operation 0, wb_en 1. **ADDI x0,x0,0** → wb_en 0.
- **Backpressure:** `out_ready`=0 with 3 back-to-back valid instructions → exactly 2 accepted, `in_ready`=0 from the cycle after the 2nd accept. On `out_ready`=1 they emerge in order on consecutive cycles, then the 3rd is accepted.
- **Illegal 0x0000000B** → illegal 1, wb_en 0.
- **SLLI with imm[11:5]=0x20** → illegal 1.
- **flush with both entries full** → `out_valid`=0 and `in_ready`=1 next cycle.
- **Reset mid-stall** → same as flush, plus all data outputs 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, funct3 and ALU-code constants plus the decoded-instruction word
// used by the RV32I ALU decode stage.
package alu_pkg;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;

  localparam logic [2:0] F3_ADD_SUB = 3'd0;
  localparam logic [2:0] F3_SLL     = 3'd1;
  localparam logic [2:0] F3_SLT     = 3'd2;
  localparam logic [2:0] F3_SLTU    = 3'd3;
  localparam logic [2:0] F3_XOR     = 3'd4;
  localparam logic [2:0] F3_SR      = 3'd5;
  localparam logic [2:0] F3_OR      = 3'd6;
  localparam logic [2:0] F3_AND     = 3'd7;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SLL  = 3'd1,
    ALU_SLT  = 3'd2,
    ALU_SLTU = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_SR   = 3'd5,
    ALU_AND  = 3'd6,
    ALU_OR   = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        src_a_pc;
    logic        src_a_zero;
    logic        src_b_imm;
    logic        mask_b5;
    alu_op_e     operation;
    logic        logic_arithmetic;
    logic        add_sub;
    logic        wb_en;
    logic        illegal;
  } alu_dec_t;

  // The ALU numbers AND/OR the other way round from RISC-V funct3.
  function automatic alu_op_e alu_op_from_funct3(input logic [2:0] funct3);
    case (funct3)
      F3_ADD_SUB: alu_op_from_funct3 = ALU_ADD;
      F3_SLL:     alu_op_from_funct3 = ALU_SLL;
      F3_SLT:     alu_op_from_funct3 = ALU_SLT;
      F3_SLTU:    alu_op_from_funct3 = ALU_SLTU;
      F3_XOR:     alu_op_from_funct3 = ALU_XOR;
      F3_SR:      alu_op_from_funct3 = ALU_SR;
      F3_OR:      alu_op_from_funct3 = ALU_OR;
      F3_AND:     alu_op_from_funct3 = ALU_AND;
      default:    alu_op_from_funct3 = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/alu_decode_comb.sv
// Combinational RV32I decoder: instruction word and pc to the ALU control word.
// Illegal instructions keep only pc and the illegal flag; every other field is 0.
module alu_decode_comb
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output alu_dec_t    dec
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       is_shift;
  logic       op_legal;
  logic       op_imm_legal;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign is_shift = (funct3 == F3_SLL) || (funct3 == F3_SR);

  // funct7 / imm[11:5] legality for register and immediate forms
  always_comb begin
    op_legal     = 1'b0;
    op_imm_legal = 1'b1;
    if (funct7 == F7_BASE) begin
      op_legal = 1'b1;
    end else if (funct7 == F7_ALT) begin
      op_legal = (funct3 == F3_ADD_SUB) || (funct3 == F3_SR);
    end else begin
      op_legal = 1'b0;
    end
    case (funct3)
      F3_SLL:  op_imm_legal = (funct7 == F7_BASE);
      F3_SR:   op_imm_legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
      default: op_imm_legal = 1'b1;
    endcase
  end

  // field decode per opcode
  always_comb begin
    dec    = '0;
    dec.pc = pc;
    case (opcode)
      OPC_OP: begin
        if (op_legal) begin
          dec.rs1              = rs1;
          dec.rs2              = rs2;
          dec.rd               = rd;
          dec.operation        = alu_op_from_funct3(funct3);
          dec.add_sub          = (funct3 == F3_ADD_SUB) && funct7[5];
          dec.logic_arithmetic = (funct3 == F3_SR) && funct7[5];
          dec.mask_b5          = is_shift;
          dec.wb_en            = (rd != 5'd0);
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        if (op_imm_legal) begin
          dec.rs1              = rs1;
          dec.rd               = rd;
          dec.src_b_imm        = 1'b1;
          dec.operation        = alu_op_from_funct3(funct3);
          dec.logic_arithmetic = (funct3 == F3_SR) && funct7[5];
          dec.wb_en            = (rd != 5'd0);
          // shifts carry only shamt so the ALU never sees imm[11:5] as shift distance
          if (is_shift) begin
            dec.imm = {27'd0, rs2};
          end else begin
            dec.imm = {{20{instr[31]}}, instr[31:20]};
          end
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        dec.rd         = rd;
        dec.src_a_zero = 1'b1;
        dec.src_b_imm  = 1'b1;
        dec.imm        = {instr[31:12], 12'd0};
        dec.wb_en      = (rd != 5'd0);
      end
      OPC_AUIPC: begin
        dec.rd        = rd;
        dec.src_a_pc  = 1'b1;
        dec.src_b_imm = 1'b1;
        dec.imm       = {instr[31:12], 12'd0};
        dec.wb_en     = (rd != 5'd0);
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_decode_stage.sv
// Registered RV32I ALU decode stage: decoder at the input, 2-entry skid buffer
// at the output so in_ready comes from a flop and throughput holds under stall.
module alu_decode_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_src_a_pc,
  output logic            out_src_a_zero,
  output logic            out_src_b_imm,
  output logic            out_mask_b5,
  output logic [2:0]      out_operation,
  output logic            out_logic_arithmetic,
  output logic            out_add_sub,
  output logic            out_wb_en,
  output logic            out_illegal
);

  alu_dec_t decoded;
  alu_dec_t main_entry;
  alu_dec_t skid_entry;
  alu_dec_t main_next;
  alu_dec_t skid_next;
  logic     main_valid;
  logic     skid_valid;
  logic     main_valid_next;
  logic     skid_valid_next;
  logic     accept;
  logic     transfer;

  alu_decode_comb u_decode (
    .instr (in_instr),
    .pc    (in_pc),
    .dec   (decoded)
  );

  assign accept   = in_valid & in_ready;
  assign transfer = main_valid & out_ready;

  // skid-buffer next state; main only changes when empty or draining
  always_comb begin
    main_next       = main_entry;
    skid_next       = skid_entry;
    main_valid_next = main_valid;
    skid_valid_next = skid_valid;
    if (flush) begin
      main_valid_next = 1'b0;
      skid_valid_next = 1'b0;
    end else if (skid_valid) begin
      if (transfer) begin
        main_next       = skid_entry;
        main_valid_next = 1'b1;
        skid_valid_next = 1'b0;
      end else begin
        main_valid_next = 1'b1;
      end
    end else if (accept) begin
      if (!main_valid || transfer) begin
        main_next       = decoded;
        main_valid_next = 1'b1;
      end else begin
        skid_next       = decoded;
        skid_valid_next = 1'b1;
      end
    end else if (transfer) begin
      main_valid_next = 1'b0;
    end else begin
      main_valid_next = main_valid;
    end
  end

  // state registers; in_ready is the registered inverse of skid occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_entry <= '0;
      skid_entry <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      main_entry <= main_next;
      skid_entry <= skid_next;
      main_valid <= main_valid_next;
      skid_valid <= skid_valid_next;
      in_ready   <= ~skid_valid_next;
    end
  end

  assign out_valid            = main_valid;
  assign out_pc               = main_entry.pc;
  assign out_imm              = main_entry.imm;
  assign out_rs1              = main_entry.rs1;
  assign out_rs2              = main_entry.rs2;
  assign out_rd               = main_entry.rd;
  assign out_src_a_pc         = main_entry.src_a_pc;
  assign out_src_a_zero       = main_entry.src_a_zero;
  assign out_src_b_imm        = main_entry.src_b_imm;
  assign out_mask_b5          = main_entry.mask_b5;
  assign out_operation        = main_entry.operation;
  assign out_logic_arithmetic = main_entry.logic_arithmetic;
  assign out_add_sub          = main_entry.add_sub;
  assign out_wb_en            = main_entry.wb_en;
  assign out_illegal          = main_entry.illegal;

endmodule
